// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Runs in the clk_50MHz domain with a divided pixel-tick enable rather than a
// derived clock. Produces the raster position, visible-area and sync decodes,
// line/frame/vblank event pulses and a wrapping frame counter for the game
// logic's once-per-frame updates.
//
// The raster order for both axes is display, front porch, sync, back porch.
// All decodes are computed from the position about to be presented and are
// registered alongside it, so every output describes the current (x,y) and no
// input reaches an output combinationally.

module vga_timing_gen #(
   parameter int   H_DISPLAY = 640,
   parameter int   H_FRONT   = 16,
   parameter int   H_SYNC    = 96,
   parameter int   H_BACK    = 48,
   parameter int   V_DISPLAY = 480,
   parameter int   V_FRONT   = 10,
   parameter int   V_SYNC    = 2,
   parameter int   V_BACK    = 33,
   parameter logic HSYNC_POL = 1'b0,
   parameter logic VSYNC_POL = 1'b0,
   parameter int   CLK_DIV   = 2,
   parameter int   CW        = 10,
   parameter int   FCW       = 16
) (
   input  logic           clk_50MHz,
   input  logic           reset,
   input  logic           enable,
   output logic           p_tick,
   output logic [CW-1:0]  x,
   output logic [CW-1:0]  y,
   output logic           video_on,
   output logic           hsync,
   output logic           vsync,
   output logic           line_start,
   output logic           frame_start,
   output logic           vblank_start,
   output logic [FCW-1:0] frame_count
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   // Divider width; a CLK_DIV of 1 still gets a one-bit counter that stays 0.
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   localparam logic [CW-1:0] X_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] Y_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] X_VIS    = CW'(H_DISPLAY);
   localparam logic [CW-1:0] Y_VIS    = CW'(V_DISPLAY);
   localparam logic [CW-1:0] HS_BEGIN = CW'(H_DISPLAY + H_FRONT);
   localparam logic [CW-1:0] HS_END   = CW'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam logic [CW-1:0] VS_BEGIN = CW'(V_DISPLAY + V_FRONT);
   localparam logic [CW-1:0] VS_END   = CW'(V_DISPLAY + V_FRONT + V_SYNC);

   logic [DW-1:0] div;
   logic          div_last;
   logic          pix_tick;
   logic          advance;

   logic          x_wrap;
   logic          y_wrap;
   logic [CW-1:0] x_nxt;
   logic [CW-1:0] y_nxt;

   logic          video_nxt;
   logic          hsync_nxt;
   logic          vsync_nxt;
   logic          line_nxt;
   logic          frame_nxt;
   logic          vblank_nxt;

   assign div_last = (div == DIV_LAST);

   // pix_tick is the frozen copy of p_tick: it survives an enable stall so a
   // tick pending when enable drops is consumed on the first enabled edge and
   // the raster loses exactly the stalled cycles, no more.
   assign advance = enable && pix_tick;

   // Pixel divider and tick strobes; everything holds while enable is low,
   // but the visible p_tick is forced low during a stall.
   always_ff @(posedge clk_50MHz) begin
      if (reset) begin
         div      <= '0;
         pix_tick <= 1'b0;
         p_tick   <= 1'b0;
      end else begin
         p_tick <= enable && div_last;
         if (enable) begin
            pix_tick <= div_last;
            div      <= div_last ? '0 : div + 1'b1;
         end
      end
   end

   // Position that will be presented after the next advance.
   always_comb begin
      x_wrap = (x == X_LAST);
      y_wrap = (y == Y_LAST);
      x_nxt  = x_wrap ? '0 : x + 1'b1;
      y_nxt  = y;
      if (x_wrap) begin
         y_nxt = y_wrap ? '0 : y + 1'b1;
      end
   end

   // Decodes of the next position, registered together with it below.
   always_comb begin
      video_nxt  = (x_nxt < X_VIS) && (y_nxt < Y_VIS);
      hsync_nxt  = ((x_nxt >= HS_BEGIN) && (x_nxt < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
      vsync_nxt  = ((y_nxt >= VS_BEGIN) && (y_nxt < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
      line_nxt   = (x_nxt == '0);
      frame_nxt  = line_nxt && (y_nxt == '0);
      vblank_nxt = line_nxt && (y_nxt == Y_VIS);
   end

   // Raster position, level decodes, event pulses and frame counter.
   // Pulses default low every cycle so they last exactly one clock; the reset
   // state itself never produces a pulse.
   always_ff @(posedge clk_50MHz) begin
      if (reset) begin
         x            <= '0;
         y            <= '0;
         video_on     <= 1'b1;
         hsync        <= ~HSYNC_POL;
         vsync        <= ~VSYNC_POL;
         line_start   <= 1'b0;
         frame_start  <= 1'b0;
         vblank_start <= 1'b0;
         frame_count  <= '0;
      end else begin
         line_start   <= 1'b0;
         frame_start  <= 1'b0;
         vblank_start <= 1'b0;
         if (advance) begin
            x            <= x_nxt;
            y            <= y_nxt;
            video_on     <= video_nxt;
            hsync        <= hsync_nxt;
            vsync        <= vsync_nxt;
            line_start   <= line_nxt;
            frame_start  <= frame_nxt;
            vblank_start <= vblank_nxt;
            if (x_wrap && y_wrap) begin
               frame_count <= frame_count + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Three instances share one clock: the default
// 640x480 configuration, a tiny 8x6 raster with CLK_DIV=1 and FCW=2, and a
// 12x8 raster with CLK_DIV=3. Only one instance is stepped at a time; the
// others sit in reset. Expected values come from a hand-written table and
// from an arithmetic model based on the count of enabled edges since reset.

module tb_vga_timing_gen;

   typedef struct {
      int d, hd, hf, hs, hb, vd, vf, vs, vb, hp, vp, fcw;
   } cfg_t;

   typedef struct {
      int x, y;
      bit vid, hs, vs, pt, ls, fs, vb;
      int fc;
   } exp_t;

   typedef struct {
      bit   rst;
      bit   en;
      exp_t e;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int k_d = 0, k_s = 0, k_m = 0;

   cfg_t cfg_d, cfg_s, cfg_m;
   vec_t tbl[$];

   // default instance
   logic        rst_d = 1'b1, en_d = 1'b1;
   logic        pt_d, vid_d, hs_d, vs_d, ls_d, fs_d, vb_d;
   logic [9:0]  x_d, y_d;
   logic [15:0] fc_d;

   // tiny instance
   logic        rst_s = 1'b1, en_s = 1'b1;
   logic        pt_s, vid_s, hs_s, vs_s, ls_s, fs_s, vb_s;
   logic [3:0]  x_s, y_s;
   logic [1:0]  fc_s;

   // divided instance
   logic        rst_m = 1'b1, en_m = 1'b1;
   logic        pt_m, vid_m, hs_m, vs_m, ls_m, fs_m, vb_m;
   logic [4:0]  x_m, y_m;
   logic [15:0] fc_m;

   vga_timing_gen dut_d (
      .clk_50MHz(clk), .reset(rst_d), .enable(en_d), .p_tick(pt_d),
      .x(x_d), .y(y_d), .video_on(vid_d), .hsync(hs_d), .vsync(vs_d),
      .line_start(ls_d), .frame_start(fs_d), .vblank_start(vb_d),
      .frame_count(fc_d));

   vga_timing_gen #(
      .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
      .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .CLK_DIV(1), .CW(4), .FCW(2)
   ) dut_s (
      .clk_50MHz(clk), .reset(rst_s), .enable(en_s), .p_tick(pt_s),
      .x(x_s), .y(y_s), .video_on(vid_s), .hsync(hs_s), .vsync(vs_s),
      .line_start(ls_s), .frame_start(fs_s), .vblank_start(vb_s),
      .frame_count(fc_s));

   vga_timing_gen #(
      .H_DISPLAY(5), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(3), .CW(5), .FCW(16)
   ) dut_m (
      .clk_50MHz(clk), .reset(rst_m), .enable(en_m), .p_tick(pt_m),
      .x(x_m), .y(y_m), .video_on(vid_m), .hsync(hs_m), .vsync(vs_m),
      .line_start(ls_m), .frame_start(fs_m), .vblank_start(vb_m),
      .frame_count(fc_m));

   // k = enabled edges since reset release (release edge is k=1).
   // Pixel index n advances on the edge after each p_tick, p_tick on k%d==0.
   function automatic exp_t model(cfg_t c, int k, bit en_edge);
      exp_t e;
      int   n, ht, vt;
      bit   adv;
      ht    = c.hd + c.hf + c.hs + c.hb;
      vt    = c.vd + c.vf + c.vs + c.vb;
      n     = (k <= 0) ? 0 : (k - 1) / c.d;
      e.x   = n % ht;
      e.y   = (n / ht) % vt;
      e.fc  = (n / (ht * vt)) % (1 << c.fcw);
      e.vid = (e.x < c.hd) && (e.y < c.vd);
      e.hs  = (e.x >= c.hd + c.hf && e.x < c.hd + c.hf + c.hs) ? (c.hp != 0) : (c.hp == 0);
      e.vs  = (e.y >= c.vd + c.vf && e.y < c.vd + c.vf + c.vs) ? (c.vp != 0) : (c.vp == 0);
      adv   = en_edge && (k >= 2) && ((k - 1) % c.d == 0);
      e.pt  = en_edge && (k >= 1) && (k % c.d == 0);
      e.ls  = adv && (e.x == 0);
      e.fs  = e.ls && (e.y == 0);
      e.vb  = e.ls && (e.y == c.vd);
      return e;
   endfunction

   function automatic vec_t mk(bit r, bit en, int x, int y, bit vid, bit hs, bit vs,
                               bit pt, bit ls, bit fs, bit vb, int fc);
      vec_t v;
      v.rst = r;  v.en = en;
      v.e.x = x;  v.e.y = y;  v.e.vid = vid; v.e.hs = hs; v.e.vs = vs;
      v.e.pt = pt; v.e.ls = ls; v.e.fs = fs; v.e.vb = vb; v.e.fc = fc;
      return v;
   endfunction

   task automatic check(input string name, input exp_t e, input logic [31:0] ax,
                        input logic [31:0] ay, input logic avid, input logic ahs,
                        input logic avs, input logic apt, input logic als,
                        input logic afs, input logic avb, input logic [31:0] afc);
      n_tests++;
      if (ax !== e.x || ay !== e.y || avid !== e.vid || ahs !== e.hs || avs !== e.vs ||
          apt !== e.pt || als !== e.ls || afs !== e.fs || avb !== e.vb || afc !== e.fc) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got x=%0d y=%0d vid=%b hs=%b vs=%b pt=%b ls=%b fs=%b vb=%b fc=%0d; want x=%0d y=%0d vid=%b hs=%b vs=%b pt=%b ls=%b fs=%b vb=%b fc=%0d",
                  name, cyc, ax, ay, avid, ahs, avs, apt, als, afs, avb, afc,
                  e.x, e.y, e.vid, e.hs, e.vs, e.pt, e.ls, e.fs, e.vb, e.fc);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0d, want %0d", name, cyc, act, exp);
      end
   endtask

   task automatic step_d(input bit r, input bit e);
      rst_d = r; en_d = e;
      @(posedge clk); #1; cyc++;
      if (r) k_d = 0; else if (e) k_d++;
      check("dflt", model(cfg_d, k_d, !r && e), 32'(x_d), 32'(y_d), vid_d, hs_d, vs_d,
            pt_d, ls_d, fs_d, vb_d, 32'(fc_d));
   endtask

   task automatic step_s(input bit r, input bit e);
      rst_s = r; en_s = e;
      @(posedge clk); #1; cyc++;
      if (r) k_s = 0; else if (e) k_s++;
      check("tiny", model(cfg_s, k_s, !r && e), 32'(x_s), 32'(y_s), vid_s, hs_s, vs_s,
            pt_s, ls_s, fs_s, vb_s, 32'(fc_s));
   endtask

   task automatic step_m(input bit r, input bit e);
      rst_m = r; en_m = e;
      @(posedge clk); #1; cyc++;
      if (r) k_m = 0; else if (e) k_m++;
      check("div3", model(cfg_m, k_m, !r && e), 32'(x_m), 32'(y_m), vid_m, hs_m, vs_m,
            pt_m, ls_m, fs_m, vb_m, 32'(fc_m));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   int t_rel, t_prev, t_ls, n_fs, n_ls, n_pt, n_hs, n_vid, hs_min, hs_max, max_x, cnt;
   bit found;

   initial begin
      cfg_d = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 16};
      cfg_s = '{1, 4, 1, 2, 1, 3, 1, 1, 1, 1, 0, 2};
      cfg_m = '{3, 5, 2, 3, 2, 4, 1, 2, 1, 0, 0, 16};

      // tiny raster: hsync active-high at x=5,6; visible x<4, y<3
      //                  r  en x  y  vid hs vs pt ls fs vb fc
      tbl.push_back(mk(1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 2, 0, 1, 0, 1, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 3, 0, 1, 0, 1, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 4, 0, 0, 0, 1, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 5, 0, 0, 1, 1, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 6, 0, 0, 1, 1, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 7, 0, 0, 0, 1, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 1, 1, 0, 1, 1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, 1, 1, 0, 1, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 2, 1, 1, 0, 1, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 2, 0, 1, 0, 1, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 3, 0, 1, 0, 1, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 4, 0, 0, 0, 1, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 5, 0, 0, 1, 1, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 6, 0, 0, 1, 1, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 7, 0, 0, 0, 1, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 1, 1, 0, 1, 1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, 1, 1, 0, 1, 1, 0, 0, 0, 0));

      repeat (2) @(posedge clk);
      #1;

      foreach (tbl[i]) begin
         rst_s = tbl[i].rst; en_s = tbl[i].en;
         @(posedge clk); #1; cyc++;
         check($sformatf("tbl[%0d]", i), tbl[i].e, 32'(x_s), 32'(y_s), vid_s, hs_s, vs_s,
               pt_s, ls_s, fs_s, vb_s, 32'(fc_s));
      end

      // tiny raster: five frames, 48-cycle frame period, frame_count wraps 3->0
      step_s(1, 1);
      n_fs = 0; max_x = 0; t_rel = 0; t_prev = 0;
      for (int i = 1; i <= 250; i++) begin
         step_s(0, 1);
         if (i == 1) t_rel = cyc;
         if (int'(x_s) > max_x) max_x = int'(x_s);
         if (fs_s === 1'b1) begin
            if (n_fs == 0) check_int("tiny first frame_start", cyc - t_rel, 48);
            else           check_int("tiny frame period", cyc - t_prev, 48);
            t_prev = cyc; n_fs++;
         end
      end
      check_int("tiny frame_start count", n_fs, 5);
      check_int("tiny x max", max_x, 7);
      check_int("tiny frame_count after wrap", int'(fc_s), 1);
      rst_s = 1'b1;

      // divided raster: frame/line periods, stall of 37, mid-frame reset
      step_m(1, 1);
      n_fs = 0; n_ls = 0; t_ls = 0;
      for (int i = 1; i <= 700 && n_fs < 2; i++) begin
         step_m(0, 1);
         if (i == 1) t_rel = cyc;
         if (ls_m === 1'b1) begin
            if (n_ls > 0) check_int("div3 line period", cyc - t_ls, 36);
            t_ls = cyc; n_ls++;
         end
         if (fs_m === 1'b1) begin
            if (n_fs == 0) check_int("div3 first frame_start", cyc - t_rel, 288);
            else           check_int("div3 frame period", cyc - t_prev, 288);
            t_prev = cyc; n_fs++;
         end
      end
      check_int("div3 frame_start count", n_fs, 2);
      check_int("div3 frame_count", int'(fc_m), 2);

      found = 0;
      for (int i = 0; i < 400 && !found; i++) begin
         step_m(0, 1);
         if (x_m == 5'd4 && y_m == 5'd3) found = 1;
      end
      check_int("div3 reach stall point", int'(found), 1);
      cnt = 0;
      repeat (37) begin
         step_m(0, 0);
         if (pt_m | ls_m | fs_m | vb_m) cnt++;
      end
      check_int("div3 stall strobes", cnt, 0);
      check_int("div3 stall hold x", int'(x_m), 4);
      check_int("div3 stall hold y", int'(y_m), 3);
      found = 0;
      for (int i = 0; i < 400 && !found; i++) begin
         step_m(0, 1);
         if (fs_m === 1'b1) found = 1;
      end
      check_int("div3 frame_start after stall", int'(found), 1);
      check_int("div3 frame period across stall", cyc - t_prev, 288 + 37);

      found = 0;
      for (int i = 0; i < 400 && !found; i++) begin
         step_m(0, 1);
         if (y_m == 5'd2) found = 1;
      end
      check_int("div3 reach reset point", int'(found), 1);
      step_m(1, 1);
      found = 0;
      for (int i = 1; i <= 400 && !found; i++) begin
         step_m(0, 1);
         if (i == 1) t_rel = cyc;
         if (fs_m === 1'b1) found = 1;
      end
      check_int("div3 frame_start after reset seen", int'(found), 1);
      check_int("div3 frame_start after reset", cyc - t_rel, 288);
      rst_m = 1'b1;

      // default raster: two lines of decode, p_tick duty, stall, reset in hsync
      step_d(1, 1);
      n_ls = 0; n_pt = 0; n_hs = 0; n_vid = 0; hs_min = 9999; hs_max = -1;
      for (int i = 1; i <= 3400; i++) begin
         step_d(0, 1);
         if (i == 1) t_rel = cyc;
         if (pt_d === 1'b1) n_pt++;
         if (ls_d === 1'b1) begin
            if (n_ls == 0) check_int("dflt first line_start", cyc - t_rel, 1600);
            else           check_int("dflt line period", cyc - t_ls, 1600);
            t_ls = cyc; n_ls++;
         end
         if (y_d == 10'd1) begin
            if (hs_d === 1'b0) begin
               n_hs++;
               if (int'(x_d) < hs_min) hs_min = int'(x_d);
               if (int'(x_d) > hs_max) hs_max = int'(x_d);
            end
            if (vid_d === 1'b1) n_vid++;
         end
      end
      check_int("dflt line_start count", n_ls, 2);
      check_int("dflt p_tick count", n_pt, 1700);
      check_int("dflt hsync low cycles", n_hs, 192);
      check_int("dflt hsync first x", hs_min, 656);
      check_int("dflt hsync last x", hs_max, 751);
      check_int("dflt video_on cycles", n_vid, 1280);

      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         step_d(0, 1);
         if (x_d == 10'd100) found = 1;
      end
      check_int("dflt reach stall point", int'(found), 1);
      cnt = 0;
      repeat (37) begin
         step_d(0, 0);
         if (pt_d | ls_d | fs_d | vb_d) cnt++;
      end
      check_int("dflt stall strobes", cnt, 0);
      check_int("dflt stall hold x", int'(x_d), 100);
      check_int("dflt stall hold y", int'(y_d), 2);
      check_int("dflt stall hold frame_count", int'(fc_d), 0);

      found = 0;
      for (int i = 0; i < 1500 && !found; i++) begin
         step_d(0, 1);
         if (x_d == 10'd700) found = 1;
      end
      check_int("dflt reach hsync reset point", int'(found), 1);
      check_int("dflt hsync active at 700", int'(hs_d), 0);
      step_d(1, 1);
      check_int("dflt reset x", int'(x_d), 0);
      check_int("dflt reset y", int'(y_d), 0);
      check_int("dflt reset hsync", int'(hs_d), 1);
      check_int("dflt reset vsync", int'(vs_d), 1);
      check_int("dflt reset video_on", int'(vid_d), 1);
      check_int("dflt reset frame_count", int'(fc_d), 0);
      repeat (4) step_d(0, 1);
      rst_d = 1'b1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
